bus_transaction_unit: RTL and testbench
=======================================

// Module: bus_transaction_unit
// PURPOSE
//   Memory-side partner of the CPU controller: accepts one load/store command per transaction,
//   runs it on the pipelined system bus, and returns waitRequest/readValid/dataSelectBits to the
//   controller's stall logic. Handles byte lanes, read alignment/extension, misalignment and bus timeout.
// PARAMETERS
//   TIMEOUT_CYCLES  255  cycles in BUS_REQ+BUS_WAIT before a transaction is aborted (2..1023)
// PORTS
//   clk                 in   1   system clock
//   reset               in   1   synchronous, active-high reset
//   cmdValid            in   1   controller issues a command (sampled only in IDLE)
//   cmdWrite            in   1   1 = store, 0 = load
//   cmdSize             in   2   00 byte, 01 half, 10 word, 11 reserved
//   cmdSigned           in   1   sign-extend load result
//   cmdAddress          in   32  byte address
//   cmdWriteData        in   32  store data, right-justified
//   waitRequest         out  1   high while a transaction is in flight
//   readValid           out  1   one-cycle pulse, readData valid
//   readData            out  32  aligned, extended load data
//   dataSelectBits      out  2   registered cmdAddress[1:0] of current/last command
//   misaligned          out  1   one-cycle fault pulse
//   busError            out  1   one-cycle timeout pulse
//   busAddress          out  32  word address {addr[31:2],2'b00}
//   busRead / busWrite  out  1   bus strobes, held until busWaitRequest low
//   busByteEnable       out  4   lane enables
//   busWriteData        out  32  lane-replicated store data
//   busWaitRequest      in   1   slave stall
//   busReadData         in   32  read data
//   busReadDataValid    in   1   read data strobe
// BEHAVIOUR
//   Reset: state IDLE, timeout counter 0, every output 0. Reset mid-transaction drops strobes on that edge;
//     a later busReadDataValid is ignored.
//   States: IDLE, BUS_REQ, BUS_WAIT.
//   IDLE: cmdValid=1 -> latch command. Fault check: half with addr[0]=1, word with addr[1:0]!=0,
//     or cmdSize=11 -> misaligned=1 next cycle, stay IDLE, no bus cycle. Else -> BUS_REQ.
//   BUS_REQ: busRead/busWrite=1, address/enables/data stable. busWaitRequest=0 at edge: write -> IDLE;
//     read -> BUS_WAIT. busReadDataValid in the same cycle as acceptance is not legal for the slave.
//   BUS_WAIT: strobes 0. busReadDataValid=1 -> readValid=1 next cycle with readData, -> IDLE.
//   waitRequest = 1 in BUS_REQ and BUS_WAIT, 0 in IDLE; cmdValid while waitRequest=1 is ignored.
//   Latency (no stalls): write 2 cycles cmd->IDLE; read 2 + slave latency cycles to readValid.
//   Byte enables: byte 4'b0001<<a[1:0]; half 4'b0011<<a[1:0]; word 4'b1111.
//   Write data: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
//   Read data: shift busReadData right by 8*a[1:0]; byte/half zero- or sign-extended per cmdSigned.
//   Timeout: counter clears entering BUS_REQ, counts in BUS_REQ/BUS_WAIT; on reaching TIMEOUT_CYCLES
//     strobes drop, busError=1 next cycle, -> IDLE. busReadDataValid on the terminal cycle wins (no error).
//   readValid, misaligned, busError are mutually exclusive single-cycle pulses; readData holds until next read.
// TESTING
//   Signed byte load 0x0000_1003, slave returns 0x80AA_BBCC after 1 cycle -> byteEnable 1000, readData 0xFFFF_FF80.
//   Half store 0x0000_2002 data 0x1234_ABCD, busWaitRequest high 3 cycles -> byteEnable 1100,
//     busWriteData 0xABCD_ABCD, busWrite held 4 cycles, waitRequest low on following cycle.
//   Word load 0x0000_4001 -> misaligned pulse 1 cycle, busRead never asserted; cmdSize=11 same.
//   TIMEOUT_CYCLES=8, slave never returns readDataValid -> busError pulse after 8 cycles, IDLE; late valid ignored.
//   Reset asserted in BUS_WAIT -> all outputs 0 next cycle; fresh unsigned half load 0x0000_0002 returns 0x0000_xxxx.
//   Back-to-back word store then load with zero slave stalls -> cmdValid accepted each IDLE, no dropped command.

Source files
------------

// File: rtl/bus_transaction_unit.sv
// Memory-side bus transaction unit: runs one load/store per command on a pipelined
// system bus, with byte-lane steering, read alignment/extension, misalignment and timeout faults.
module bus_transaction_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmdValid,
  input  logic        cmdWrite,
  input  logic [1:0]  cmdSize,
  input  logic        cmdSigned,
  input  logic [31:0] cmdAddress,
  input  logic [31:0] cmdWriteData,
  output logic        waitRequest,
  output logic        readValid,
  output logic [31:0] readData,
  output logic [1:0]  dataSelectBits,
  output logic        misaligned,
  output logic        busError,
  output logic [31:0] busAddress,
  output logic        busRead,
  output logic        busWrite,
  output logic [3:0]  busByteEnable,
  output logic [31:0] busWriteData,
  input  logic        busWaitRequest,
  input  logic [31:0] busReadData,
  input  logic        busReadDataValid
);

  typedef enum logic [1:0] {IDLE, BUS_REQ, BUS_WAIT} state_t;

  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [9:0]  tmo_q;
  logic        wr_q, sgn_q;
  logic [1:0]  size_q, dsel_q;
  logic        wait_q, rvld_q, mis_q, err_q, brd_q, bwr_q;
  logic [31:0] rdata_q, baddr_q, bwdata_q;
  logic [3:0]  be_q;

  logic        fault;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, shifted, rdata_d;
  logic        tmo_last;

  always_comb begin
    fault   = 1'b0;
    be_d    = 4'b1111;
    wdata_d = cmdWriteData;
    case (cmdSize)
      2'b00: begin
        be_d    = 4'b0001 << cmdAddress[1:0];
        wdata_d = {4{cmdWriteData[7:0]}};
      end
      2'b01: begin
        fault   = cmdAddress[0];
        be_d    = 4'b0011 << cmdAddress[1:0];
        wdata_d = {2{cmdWriteData[15:0]}};
      end
      2'b10: fault = (cmdAddress[1:0] != 2'b00);
      default: fault = 1'b1;
    endcase
  end

  // Load data is aligned against the lane the command addressed, then extended.
  always_comb begin
    shifted = busReadData >> {dsel_q, 3'b000};
    case (size_q)
      2'b00:   rdata_d = sgn_q ? {{24{shifted[7]}}, shifted[7:0]} : {24'b0, shifted[7:0]};
      2'b01:   rdata_d = sgn_q ? {{16{shifted[15]}}, shifted[15:0]} : {16'b0, shifted[15:0]};
      default: rdata_d = shifted;
    endcase
  end

  assign tmo_last = (tmo_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tmo_q    <= '0;
      wr_q     <= 1'b0;
      sgn_q    <= 1'b0;
      size_q   <= '0;
      dsel_q   <= '0;
      wait_q   <= 1'b0;
      rvld_q   <= 1'b0;
      mis_q    <= 1'b0;
      err_q    <= 1'b0;
      brd_q    <= 1'b0;
      bwr_q    <= 1'b0;
      rdata_q  <= '0;
      baddr_q  <= '0;
      bwdata_q <= '0;
      be_q     <= '0;
    end else begin
      rvld_q <= 1'b0;
      mis_q  <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (cmdValid) begin
          dsel_q <= cmdAddress[1:0];
          if (fault) begin
            mis_q <= 1'b1;
          end else begin
            wr_q     <= cmdWrite;
            sgn_q    <= cmdSigned;
            size_q   <= cmdSize;
            baddr_q  <= {cmdAddress[31:2], 2'b00};
            be_q     <= be_d;
            bwdata_q <= wdata_d;
            brd_q    <= ~cmdWrite;
            bwr_q    <= cmdWrite;
            wait_q   <= 1'b1;
            tmo_q    <= '0;
            state_q  <= BUS_REQ;
          end
        end
        BUS_REQ: begin
          tmo_q <= tmo_q + 10'd1;
          if (!busWaitRequest && wr_q) begin
            bwr_q   <= 1'b0;
            wait_q  <= 1'b0;
            state_q <= IDLE;
          end else if (tmo_last) begin
            // A read accepted on the terminal cycle can no longer return data in time.
            brd_q   <= 1'b0;
            bwr_q   <= 1'b0;
            wait_q  <= 1'b0;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else if (!busWaitRequest) begin
            brd_q   <= 1'b0;
            state_q <= BUS_WAIT;
          end
        end
        BUS_WAIT: begin
          tmo_q <= tmo_q + 10'd1;
          if (busReadDataValid) begin
            rvld_q  <= 1'b1;
            rdata_q <= rdata_d;
            wait_q  <= 1'b0;
            state_q <= IDLE;
          end else if (tmo_last) begin
            wait_q  <= 1'b0;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign waitRequest    = wait_q;
  assign readValid      = rvld_q;
  assign readData       = rdata_q;
  assign dataSelectBits = dsel_q;
  assign misaligned     = mis_q;
  assign busError       = err_q;
  assign busAddress     = baddr_q;
  assign busRead        = brd_q;
  assign busWrite       = bwr_q;
  assign busByteEnable  = be_q;
  assign busWriteData   = bwdata_q;

endmodule

// File: tb/tb_bus_transaction_unit.sv
// Directed bench for bus_transaction_unit with hand-computed expectations.
module tb_bus_transaction_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        cmdValid, cmdWrite, cmdSigned;
  logic [1:0]  cmdSize;
  logic [31:0] cmdAddress, cmdWriteData;
  logic        waitRequest, readValid, misaligned, busError;
  logic [31:0] readData, busAddress, busWriteData;
  logic [1:0]  dataSelectBits;
  logic        busRead, busWrite;
  logic [3:0]  busByteEnable;
  logic        busWaitRequest, busReadDataValid;
  logic [31:0] busReadData;

  int n_run = 0;
  int n_fail = 0;

  bus_transaction_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .cmdValid(cmdValid), .cmdWrite(cmdWrite), .cmdSize(cmdSize), .cmdSigned(cmdSigned),
    .cmdAddress(cmdAddress), .cmdWriteData(cmdWriteData),
    .waitRequest(waitRequest), .readValid(readValid), .readData(readData),
    .dataSelectBits(dataSelectBits), .misaligned(misaligned), .busError(busError),
    .busAddress(busAddress), .busRead(busRead), .busWrite(busWrite),
    .busByteEnable(busByteEnable), .busWriteData(busWriteData),
    .busWaitRequest(busWaitRequest), .busReadData(busReadData),
    .busReadDataValid(busReadDataValid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] d);
    cmdValid = 1'b1; cmdWrite = wr; cmdSize = sz; cmdSigned = sg;
    cmdAddress = a; cmdWriteData = d;
  endtask

  initial begin
    reset = 1'b1; cmdValid = 1'b0; cmdWrite = 1'b0; cmdSize = 2'b00; cmdSigned = 1'b0;
    cmdAddress = '0; cmdWriteData = '0; busWaitRequest = 1'b0; busReadData = '0;
    busReadDataValid = 1'b0;
    tick; tick;
    chk("rst_wait", 32'(waitRequest), 0);
    chk("rst_strobes", 32'({busRead, busWrite}), 0);
    chk("rst_pulses", 32'({readValid, misaligned, busError}), 0);
    chk("rst_be", 32'(busByteEnable), 0);
    chk("rst_addr", busAddress, 0);
    chk("rst_rdata", readData, 0);
    reset = 1'b0;
    tick;

    // Signed byte load at lane 3
    cmd(1'b0, 2'b00, 1'b1, 32'h0000_1003, 0);
    tick;
    cmdValid = 1'b0;
    chk("ld_b_read", 32'(busRead), 1);
    chk("ld_b_be", 32'(busByteEnable), 32'h8);
    chk("ld_b_addr", busAddress, 32'h0000_1000);
    chk("ld_b_dsel", 32'(dataSelectBits), 3);
    chk("ld_b_wait", 32'(waitRequest), 1);
    tick;
    chk("ld_b_read_drop", 32'(busRead), 0);
    busReadDataValid = 1'b1; busReadData = 32'h80AA_BBCC;
    tick;
    busReadDataValid = 1'b0;
    chk("ld_b_rvalid", 32'(readValid), 1);
    chk("ld_b_rdata", readData, 32'hFFFF_FF80);
    chk("ld_b_wait_lo", 32'(waitRequest), 0);
    tick;
    chk("ld_b_rvalid_pulse", 32'(readValid), 0);
    chk("ld_b_rdata_hold", readData, 32'hFFFF_FF80);

    // Half store with three stall cycles
    busWaitRequest = 1'b1;
    cmd(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD);
    tick;
    cmdValid = 1'b0;
    chk("st_h_be", 32'(busByteEnable), 32'hC);
    chk("st_h_wdata", busWriteData, 32'hABCD_ABCD);
    chk("st_h_write0", 32'(busWrite), 1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("st_h_write_held", 32'(busWrite), 1);
      chk("st_h_wait_held", 32'(waitRequest), 1);
    end
    busWaitRequest = 1'b0;
    tick;
    chk("st_h_write_done", 32'(busWrite), 0);
    chk("st_h_wait_lo", 32'(waitRequest), 0);

    // Misaligned word load, then reserved size
    cmd(1'b0, 2'b10, 1'b0, 32'h0000_4001, 0);
    tick;
    cmdValid = 1'b0;
    chk("mis_w_pulse", 32'(misaligned), 1);
    chk("mis_w_noread", 32'(busRead), 0);
    chk("mis_w_wait", 32'(waitRequest), 0);
    tick;
    chk("mis_w_pulse_end", 32'(misaligned), 0);
    chk("mis_w_noread2", 32'(busRead), 0);
    cmd(1'b0, 2'b11, 1'b0, 32'h0000_4000, 0);
    tick;
    cmdValid = 1'b0;
    chk("mis_rsv_pulse", 32'(misaligned), 1);
    chk("mis_rsv_noread", 32'(busRead), 0);
    tick;
    chk("mis_rsv_pulse_end", 32'(misaligned), 0);

    // Timeout: read accepted, slave never returns data
    cmd(1'b0, 2'b10, 1'b0, 32'h0000_3000, 0);
    tick;
    cmdValid = 1'b0;
    chk("tmo_read", 32'(busRead), 1);
    for (int i = 0; i < 7; i++) begin
      tick;
      chk("tmo_no_err", 32'(busError), 0);
      chk("tmo_busy", 32'(waitRequest), 1);
    end
    tick;
    chk("tmo_err", 32'(busError), 1);
    chk("tmo_idle", 32'(waitRequest), 0);
    busReadDataValid = 1'b1; busReadData = 32'h5555_5555;
    tick;
    busReadDataValid = 1'b0;
    chk("tmo_err_pulse", 32'(busError), 0);
    chk("tmo_late_ignored", 32'(readValid), 0);

    // Reset while waiting for read data
    cmd(1'b0, 2'b10, 1'b0, 32'h0000_0008, 0);
    tick;
    cmdValid = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mid_rst_wait", 32'(waitRequest), 0);
    chk("mid_rst_strobes", 32'({busRead, busWrite}), 0);
    chk("mid_rst_addr", busAddress, 0);
    chk("mid_rst_rdata", readData, 0);
    busReadDataValid = 1'b1; busReadData = 32'h7777_7777;
    tick;
    busReadDataValid = 1'b0;
    chk("mid_rst_late_ignored", 32'(readValid), 0);
    cmd(1'b0, 2'b01, 1'b0, 32'h0000_0002, 0);
    tick;
    cmdValid = 1'b0;
    chk("ld_h_be", 32'(busByteEnable), 32'hC);
    tick;
    busReadDataValid = 1'b1; busReadData = 32'hBEEF_1234;
    tick;
    busReadDataValid = 1'b0;
    chk("ld_h_rvalid", 32'(readValid), 1);
    chk("ld_h_rdata", readData, 32'h0000_BEEF);

    // Back-to-back word store then load, no stalls
    cmd(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
    tick;
    chk("b2b_write", 32'(busWrite), 1);
    chk("b2b_be", 32'(busByteEnable), 32'hF);
    chk("b2b_wdata", busWriteData, 32'hDEAD_BEEF);
    cmd(1'b0, 2'b10, 1'b0, 32'h0000_0014, 0);
    tick;
    chk("b2b_idle", 32'(waitRequest), 0);
    chk("b2b_busy_ignored", 32'({busRead, busWrite}), 0);
    tick;
    cmdValid = 1'b0;
    chk("b2b_read", 32'(busRead), 1);
    chk("b2b_raddr", busAddress, 32'h0000_0014);
    tick;
    busReadDataValid = 1'b1; busReadData = 32'h1122_3344;
    tick;
    busReadDataValid = 1'b0;
    chk("b2b_rvalid", 32'(readValid), 1);
    chk("b2b_rdata", readData, 32'h1122_3344);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
